// File: rtl/trade_mean_fsm.sv
// trade_mean_fsm: two-stage mean-reversion trading signal generator.
// Stage 1 registers the band comparisons of each valid sample; stage 2 is a
// FLAT/LONG/SHORT/COOLDOWN position FSM with N-sample entry confirmation,
// reversion exit, hold timeout, flush and post-exit cooldown.
// Handshake: in_valid qualifies current_data/short_sma/long_sma for one cycle;
// there is no backpressure, every valid sample is consumed on the edge it is
// presented. Outputs are registered pulses, one cycle long.
module trade_mean_fsm #(
    parameter int WIDTH     = 8,
    parameter int THRESHOLD = 5,
    parameter int CONFIRM   = 2,
    parameter int HOLD_MAX  = 64,
    parameter int COOLDOWN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] current_data,
    input  logic [WIDTH-1:0] short_sma,
    input  logic [WIDTH-1:0] long_sma,
    input  logic             flush,
    output logic             buy_signal,
    output logic             sell_signal,
    output logic [1:0]       position,
    output logic             forced_exit,
    output logic [1:0]       dbg_state_o
);

    localparam logic [1:0] ST_FLAT  = 2'd0;
    localparam logic [1:0] ST_LONG  = 2'd1;
    localparam logic [1:0] ST_SHORT = 2'd2;
    localparam logic [1:0] ST_COOL  = 2'd3;

    localparam int CW  = $clog2(CONFIRM + 1);
    localparam int HW  = $clog2(HOLD_MAX + 1);
    localparam int CLW = $clog2(COOLDOWN + 1);

    localparam logic [CW-1:0]  CONF_C = CW'(CONFIRM);
    localparam logic [HW-1:0]  HOLD_C = HW'(HOLD_MAX - 1);
    localparam logic [CLW-1:0] COOL_C = CLW'(COOLDOWN - 1);

    // One extra bit of headroom so the sum and the upper band never wrap.
    localparam logic [WIDTH:0] THR_E = (WIDTH + 1)'(THRESHOLD);
    localparam logic [WIDTH:0] MAX_E = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH:0] cur_w, sum_w, mid_w, upper_raw_w, upper_w, lower_w;
    logic           trend_w, buy_w, sell_w, rev_long_w, rev_short_w;

    assign cur_w       = {1'b0, current_data};
    assign sum_w       = {1'b0, short_sma} + {1'b0, long_sma};
    assign mid_w       = sum_w >> 1;
    assign upper_raw_w = mid_w + THR_E;
    assign upper_w     = (upper_raw_w > MAX_E) ? MAX_E : upper_raw_w;
    assign lower_w     = (mid_w > THR_E) ? (mid_w - THR_E) : '0;
    assign trend_w     = short_sma > long_sma;
    assign buy_w       = trend_w && (cur_w < lower_w);
    assign sell_w      = !trend_w && (cur_w > upper_w);
    assign rev_long_w  = cur_w >= mid_w;
    assign rev_short_w = cur_w <= mid_w;

    logic s1_valid_q, s1_buy_q, s1_sell_q, s1_rev_long_q, s1_rev_short_q;

    // Stage 1: capture the sample's qualification flags; valid lasts one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q     <= 1'b0;
            s1_buy_q       <= 1'b0;
            s1_sell_q      <= 1'b0;
            s1_rev_long_q  <= 1'b0;
            s1_rev_short_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_buy_q       <= buy_w;
                s1_sell_q      <= sell_w;
                s1_rev_long_q  <= rev_long_w;
                s1_rev_short_q <= rev_short_w;
            end
        end
    end

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  buy_cnt_q, buy_cnt_d, sell_cnt_q, sell_cnt_d;
    logic [CW-1:0]  buy_nxt, sell_nxt;
    logic [HW-1:0]  hold_q, hold_d;
    logic [CLW-1:0] cool_q, cool_d;
    logic           buy_q, buy_d, sell_q, sell_d, forced_q, forced_d;
    logic           timeout, exit_rev;

    // Next-state logic: one closing pulse per exit regardless of how many
    // exit causes coincide; forced_exit flags flush/timeout among them.
    always_comb begin
        state_d    = state_q;
        buy_cnt_d  = buy_cnt_q;
        sell_cnt_d = sell_cnt_q;
        hold_d     = hold_q;
        cool_d     = cool_q;
        buy_d      = 1'b0;
        sell_d     = 1'b0;
        forced_d   = 1'b0;
        buy_nxt    = '0;
        sell_nxt   = '0;
        timeout    = (hold_q == HOLD_C);
        exit_rev   = 1'b0;
        case (state_q)
            ST_FLAT: begin
                if (flush) begin
                    buy_cnt_d  = '0;
                    sell_cnt_d = '0;
                end else if (s1_valid_q) begin
                    buy_nxt  = s1_buy_q ?
                               ((buy_cnt_q == CONF_C) ? CONF_C : buy_cnt_q + CW'(1)) : '0;
                    sell_nxt = s1_sell_q ?
                               ((sell_cnt_q == CONF_C) ? CONF_C : sell_cnt_q + CW'(1)) : '0;
                    if (buy_nxt == CONF_C) begin
                        buy_d      = 1'b1;
                        state_d    = ST_LONG;
                        buy_cnt_d  = '0;
                        sell_cnt_d = '0;
                        hold_d     = '0;
                    end else if (sell_nxt == CONF_C) begin
                        sell_d     = 1'b1;
                        state_d    = ST_SHORT;
                        buy_cnt_d  = '0;
                        sell_cnt_d = '0;
                        hold_d     = '0;
                    end else begin
                        buy_cnt_d  = buy_nxt;
                        sell_cnt_d = sell_nxt;
                    end
                end
            end
            ST_LONG, ST_SHORT: begin
                if (state_q == ST_LONG)
                    exit_rev = s1_valid_q && (s1_rev_long_q || s1_sell_q);
                else
                    exit_rev = s1_valid_q && (s1_rev_short_q || s1_buy_q);
                if (flush || timeout || exit_rev) begin
                    buy_d      = (state_q == ST_SHORT);
                    sell_d     = (state_q == ST_LONG);
                    forced_d   = flush || timeout;
                    state_d    = ST_COOL;
                    cool_d     = '0;
                    buy_cnt_d  = '0;
                    sell_cnt_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                if (cool_q == COOL_C) begin
                    state_d    = ST_FLAT;
                    buy_cnt_d  = '0;
                    sell_cnt_d = '0;
                end else begin
                    cool_d = cool_q + CLW'(1);
                end
            end
        endcase
    end

    // State, counters and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_FLAT;
            buy_cnt_q  <= '0;
            sell_cnt_q <= '0;
            hold_q     <= '0;
            cool_q     <= '0;
            buy_q      <= 1'b0;
            sell_q     <= 1'b0;
            forced_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buy_cnt_q  <= buy_cnt_d;
            sell_cnt_q <= sell_cnt_d;
            hold_q     <= hold_d;
            cool_q     <= cool_d;
            buy_q      <= buy_d;
            sell_q     <= sell_d;
            forced_q   <= forced_d;
        end
    end

    // Position is a direct decode of the state; cooldown reports flat.
    always_comb begin
        case (state_q)
            ST_LONG:  position = 2'b01;
            ST_SHORT: position = 2'b10;
            default:  position = 2'b00;
        endcase
    end

    assign buy_signal  = buy_q;
    assign sell_signal = sell_q;
    assign forced_exit = forced_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trade_mean_fsm.sv
// Directed bench for trade_mean_fsm (WIDTH=8, THRESHOLD=5, CONFIRM=2,
// HOLD_MAX=64, COOLDOWN=4): a vector table plus hand sequences for timeout,
// flush-at-timeout and asynchronous reset.
module tb_trade_mean_fsm;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] current_data, short_sma, long_sma;
  logic       flush;
  logic       buy_signal, sell_signal, forced_exit;
  logic [1:0] position, dbg_state;

  int checks = 0;
  int errors = 0;

  trade_mean_fsm #(
    .WIDTH(8), .THRESHOLD(5), .CONFIRM(2), .HOLD_MAX(64), .COOLDOWN(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .current_data(current_data),
    .short_sma(short_sma), .long_sma(long_sma), .flush(flush),
    .buy_signal(buy_signal), .sell_signal(sell_signal), .position(position),
    .forced_exit(forced_exit), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observed vector: {buy, sell, position[1:0], forced, state[1:0]}
  typedef struct {
    logic       v;
    logic [7:0] cur;
    logic [7:0] s;
    logic [7:0] l;
    logic       fl;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] obs();
    return {buy_signal, sell_signal, position, forced_exit, dbg_state};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got b/s/pos/fx/st=%b expected %b", name, act, exp);
    end
  endtask

  // driver: present inputs, clock once, settle #1 past the edge
  task automatic cyc(input logic v, input logic [7:0] cur, input logic [7:0] s,
                     input logic [7:0] l, input logic fl);
    in_valid = v; current_data = cur; short_sma = s; long_sma = l; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0); endtask

  task automatic add(input logic v, input logic [7:0] cur, input logic [7:0] s,
                     input logic [7:0] l, input logic fl, input logic eb, input logic es,
                     input logic [1:0] ep, input logic ef, input logic [1:0] est);
    vec_t r;
    r.v = v; r.cur = cur; r.s = s; r.l = l; r.fl = fl;
    r.exp = {eb, es, ep, ef, est};
    vecs.push_back(r);
  endtask

  // sample shorthands
  task automatic a_b(input logic [1:0] st);  add(1, 100, 120, 100, 0, 0, 0, (st == 1) ? 2'b01 : 2'b00, 0, st); endtask
  task automatic a_i(input logic [1:0] st);  add(0, 0, 0, 0, 0, 0, 0, (st == 1) ? 2'b01 : (st == 2) ? 2'b10 : 2'b00, 0, st); endtask

  int bad;

  initial begin
    rst = 1'b0; in_valid = 1'b0; current_data = '0; short_sma = '0; long_sma = '0; flush = 1'b0;
    @(posedge clk); #1;
    check("reset_state", obs(), 7'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    // row expectations are outputs after that row's edge, i.e. the FSM
    // decision on the previous row's sample (flush acts on its own row)
    // entry: two buy samples
    a_b(0); a_b(0);
    add(0, 0, 0, 0, 0, 1, 0, 2'b01, 0, 1);            // buy pulse, LONG
    add(1, 111, 120, 100, 0, 0, 0, 2'b01, 0, 1);      // reversion sample
    add(1, 100, 120, 100, 0, 0, 1, 2'b00, 0, 3);      // sell pulse, cooldown
    a_b(3); a_b(3); a_b(3);                           // ignored in cooldown
    a_b(0);                                           // FLAT after 4 cycles
    a_i(0); a_i(0);                                   // cnt=1, gap
    a_b(0);
    a_i(1); vecs[$].exp = {1'b1, 1'b0, 2'b01, 1'b0, 2'd1};   // gap-tolerant buy
    add(0, 0, 0, 0, 1, 0, 1, 2'b00, 1, 3);            // flush in LONG
    a_i(3); a_i(3); a_i(3); a_i(0);
    // confirmation break
    a_b(0); add(1, 108, 120, 100, 0, 0, 0, 2'b00, 0, 0); a_b(0); a_i(0); a_i(0);
    // flush in FLAT clears counters
    a_b(0); add(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0); a_b(0); a_i(0); a_i(0);
    // short entry and reversion exit
    add(1, 120, 100, 120, 0, 0, 0, 2'b00, 0, 0);
    add(1, 120, 100, 120, 0, 0, 0, 2'b00, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2);            // sell pulse, SHORT
    add(1, 108, 100, 120, 0, 0, 0, 2'b10, 0, 2);      // reversion sample
    add(0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 3);            // buy pulse closes
    a_i(3); a_i(3); a_i(3); a_i(0);
    // boundary: upper saturates, no sell
    add(1, 255, 255, 255, 0, 0, 0, 2'b00, 0, 0);
    add(1, 255, 255, 255, 0, 0, 0, 2'b00, 0, 0);
    a_i(0); a_i(0);
    // boundary: lower clamps at 0, no buy
    add(1, 0, 3, 1, 0, 0, 0, 2'b00, 0, 0);
    add(1, 0, 3, 1, 0, 0, 0, 2'b00, 0, 0);
    a_i(0); a_i(0);
    // boundary: mid 245 without overflow (wrapped mid would reject cur=200)
    add(1, 0, 250, 240, 0, 0, 0, 2'b00, 0, 0);
    add(1, 200, 250, 240, 0, 0, 0, 2'b00, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 2'b01, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1, 2'b00, 1, 3);
    a_i(3); a_i(3); a_i(3); a_i(0);

    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].cur, vecs[i].s, vecs[i].l, vecs[i].fl);
      check($sformatf("row%0d", i), obs(), vecs[i].exp);
    end

    // timeout in SHORT: closing buy + forced_exit 64 cycles after entry
    cyc(1, 120, 100, 120, 0); cyc(1, 120, 100, 120, 0); idle();
    check("timeout_entry", obs(), {1'b0, 1'b1, 2'b10, 1'b0, 2'd2});
    bad = 0;
    for (int k = 1; k <= 63; k++) begin
      idle();
      if (obs() !== {1'b0, 1'b0, 2'b10, 1'b0, 2'd2}) bad++;
    end
    check("timeout_hold_window", 7'(bad), 7'd0);
    idle();
    check("timeout_pulse", obs(), {1'b1, 1'b0, 2'b00, 1'b1, 2'd3});
    idle();
    check("timeout_pulse_width", obs(), {1'b0, 1'b0, 2'b00, 1'b0, 2'd3});
    idle(); idle(); idle();
    check("timeout_cool_done", obs(), 7'b0);

    // flush coincident with timeout: exactly one pulse
    cyc(1, 120, 100, 120, 0); cyc(1, 120, 100, 120, 0); idle();
    check("flush_to_entry", obs(), {1'b0, 1'b1, 2'b10, 1'b0, 2'd2});
    for (int k = 1; k <= 63; k++) idle();
    cyc(0, 8'd0, 8'd0, 8'd0, 1'b1);
    check("flush_to_pulse", obs(), {1'b1, 1'b0, 2'b00, 1'b1, 2'd3});
    idle();
    check("flush_to_single", obs(), {1'b0, 1'b0, 2'b00, 1'b0, 2'd3});
    idle(); idle(); idle();

    // asynchronous reset while LONG
    cyc(1, 100, 120, 100, 0); cyc(1, 100, 120, 100, 0); idle();
    check("rst_entry", obs(), {1'b1, 1'b0, 2'b01, 1'b0, 2'd1});
    #3 rst = 1'b0;
    #1 check("rst_async", obs(), 7'b0);
    #2 rst = 1'b1;
    bad = 0;
    idle(); if (obs() !== 7'b0) bad++;
    idle(); if (obs() !== 7'b0) bad++;
    check("rst_no_pulse", 7'(bad), 7'd0);
    cyc(1, 100, 120, 100, 0); idle();
    check("rst_single_sample", obs(), 7'b0);
    cyc(1, 100, 120, 100, 0); idle();
    check("rst_reentry", obs(), {1'b1, 1'b0, 2'b01, 1'b0, 2'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
